// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between the IFU and MEMU requesters with round-robin tie-break.
// Latency: 3 cycles from request to response pulse with zero-wait memory; misaligned fetches answer in 1.
// Backpressure: holds mem_req_valid until mem_req_ready; requesters hold valid until their response pulse.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ireq_valid,
    input  logic [ADDR_WIDTH-1:0]   ireq_addr,
    output logic                    iresp_valid,
    output logic [31:0]             iresp_data,
    output logic                    iresp_err,

    input  logic                    dreq_valid,
    input  logic [ADDR_WIDTH-1:0]   dreq_addr,
    input  logic                    dreq_we,
    input  logic [DATA_WIDTH-1:0]   dreq_wdata,
    input  logic [7:0]              dreq_wstrb,
    output logic                    dresp_valid,
    output logic [DATA_WIDTH-1:0]   dresp_data,
    output logic                    dresp_err,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [7:0]              mem_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,

    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant_d;   // 1 = MEMU won the most recent grant
    logic               gnt_d;          // side owning the transfer in flight
    logic [CNT_W-1:0]   cnt;

    logic               any_req;
    logic               pick_d;
    logic               misaligned;
    logic               timeout_hit;

    always_comb begin
        any_req     = ireq_valid | dreq_valid;
        // On a tie the side opposite the previous winner takes the port.
        pick_d      = dreq_valid & (~ireq_valid | ~last_grant_d);
        misaligned  = ~pick_d & (ireq_addr[1:0] != 2'b00);
        timeout_hit = TO_EN && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b1;
            gnt_d        <= 1'b0;
            cnt          <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            iresp_data   <= '0;
            iresp_err    <= 1'b0;
            dresp_data   <= '0;
            dresp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_d        <= pick_d;
                        last_grant_d <= pick_d;
                        mem_addr     <= pick_d ? dreq_addr : ireq_addr;
                        mem_we       <= pick_d & dreq_we;
                        mem_wdata    <= pick_d ? dreq_wdata : '0;
                        mem_wstrb    <= pick_d ? dreq_wstrb : 8'h00;
                        if (misaligned) begin
                            iresp_err  <= 1'b1;
                            iresp_data <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (gnt_d) begin
                            dresp_err  <= 1'b0;
                            dresp_data <= mem_we ? '0 : mem_resp_data;
                        end else begin
                            iresp_err  <= 1'b0;
                            iresp_data <= mem_addr[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
                        end
                    end else if (timeout_hit) begin
                        if (gnt_d) begin
                            dresp_err  <= 1'b1;
                            dresp_data <= '0;
                        end else begin
                            iresp_err  <= 1'b1;
                            iresp_data <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        mem_req_valid = (state == REQ);
        iresp_valid   = (state == RESP) & ~gnt_d;
        dresp_valid   = (state == RESP) & gnt_d;
        busy          = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load, lane select, round-robin ties, misaligned fetch,
// timeout with a late response, and reset during a pending request.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        iresp_err;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic        dreq_we;
    logic [63:0] dreq_wdata;
    logic [7:0]  dreq_wstrb;
    logic        dresp_valid;
    logic [63:0] dresp_data;
    logic        dresp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .iresp_err      (iresp_err),
        .dreq_valid     (dreq_valid),
        .dreq_addr      (dreq_addr),
        .dreq_we        (dreq_we),
        .dreq_wdata     (dreq_wdata),
        .dreq_wstrb     (dreq_wstrb),
        .dresp_valid    (dresp_valid),
        .dresp_data     (dresp_data),
        .dresp_err      (dresp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Called in a REQ cycle: accept at once, respond in the next cycle, return in the RESP cycle.
    task automatic serve(input logic [63:0] rdata);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        step();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ireq_valid = 1'b0; ireq_addr = '0;
        dreq_valid = 1'b0; dreq_addr = '0; dreq_we = 1'b0; dreq_wdata = '0; dreq_wstrb = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        step(); step();

        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_iresp_valid", iresp_valid, 0);
        chk("rst_dresp_valid", dresp_valid, 0);
        chk("rst_dresp_data", dresp_data, 0);

        // Single load
        rst = 1'b0;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_0008; dreq_we = 1'b0;
        step();
        chk("ld_c1_req_valid", mem_req_valid, 1);
        chk("ld_c1_addr", mem_addr, 64'h8000_0008);
        chk("ld_c1_we", mem_we, 0);
        chk("ld_c1_busy", busy, 1);
        mem_req_ready = 1'b1;
        step();
        chk("ld_c2_req_valid", mem_req_valid, 0);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h1122_3344_5566_7788;
        step();
        mem_resp_valid = 1'b0;
        chk("ld_c3_dresp_valid", dresp_valid, 1);
        chk("ld_c3_dresp_data", dresp_data, 64'h1122_3344_5566_7788);
        chk("ld_c3_dresp_err", dresp_err, 0);
        chk("ld_c3_iresp_valid", iresp_valid, 0);
        dreq_valid = 1'b0;
        step();
        chk("ld_c4_dresp_valid", dresp_valid, 0);
        chk("ld_c4_data_held", dresp_data, 64'h1122_3344_5566_7788);
        chk("ld_c4_busy", busy, 0);

        // IFU lane select, upper then lower word
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
        step();
        chk("if_hi_addr", mem_addr, 64'h8000_0004);
        chk("if_hi_we", mem_we, 0);
        serve(64'hAAAA_AAAA_BBBB_BBBB);
        chk("if_hi_valid", iresp_valid, 1);
        chk("if_hi_data", iresp_data, 32'hAAAA_AAAA);
        chk("if_hi_err", iresp_err, 0);
        chk("if_hi_dresp_valid", dresp_valid, 0);
        ireq_valid = 1'b0;
        step();
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
        step();
        serve(64'hAAAA_AAAA_BBBB_BBBB);
        chk("if_lo_valid", iresp_valid, 1);
        chk("if_lo_data", iresp_data, 32'hBBBB_BBBB);
        ireq_valid = 1'b0;
        step();

        // Timeout then a late response in IDLE
        dreq_valid = 1'b1; dreq_addr = 64'h8000_0100; dreq_we = 1'b0;
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step(); step(); step();
        chk("to_wait4_dresp_valid", dresp_valid, 0);
        chk("to_wait4_busy", busy, 1);
        step();
        chk("to_resp_valid", dresp_valid, 1);
        chk("to_resp_err", dresp_err, 1);
        chk("to_resp_data", dresp_data, 0);
        dreq_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h5555_6666_7777_8888;
        step();
        mem_resp_valid = 1'b0;
        chk("to_late_busy", busy, 0);
        chk("to_late_dresp_valid", dresp_valid, 0);
        chk("to_late_err_held", dresp_err, 1);
        step();
        chk("to_late_idle_busy", busy, 0);
        chk("to_late_req_valid", mem_req_valid, 0);

        // Misaligned fetch
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0002;
        step();
        chk("mis_c1_valid", iresp_valid, 1);
        chk("mis_c1_err", iresp_err, 1);
        chk("mis_c1_data", iresp_data, 0);
        chk("mis_c1_req_valid", mem_req_valid, 0);
        ireq_valid = 1'b0;
        step();
        chk("mis_c2_req_valid", mem_req_valid, 0);
        chk("mis_c2_busy", busy, 0);

        // Simultaneous requests from reset: IFU, DATA, IFU
        rst = 1'b1;
        step();
        chk("rr_rst_iresp_data", iresp_data, 0);
        chk("rr_rst_iresp_err", iresp_err, 0);
        rst = 1'b0;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_1000;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_2010; dreq_we = 1'b1;
        dreq_wdata = 64'hDEAD_BEEF_CAFE_F00D; dreq_wstrb = 8'hF0;
        step();
        chk("rr1_addr", mem_addr, 64'h8000_1000);
        chk("rr1_we", mem_we, 0);
        serve(64'h1111_1111_2222_2222);
        chk("rr1_iresp_valid", iresp_valid, 1);
        chk("rr1_iresp_data", iresp_data, 32'h2222_2222);
        chk("rr1_dresp_valid", dresp_valid, 0);
        step(); step();
        chk("rr2_addr", mem_addr, 64'h8000_2010);
        chk("rr2_we", mem_we, 1);
        chk("rr2_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("rr2_wstrb", mem_wstrb, 8'hF0);
        serve(64'h9999_9999_9999_9999);
        chk("rr2_dresp_valid", dresp_valid, 1);
        chk("rr2_dresp_data", dresp_data, 0);
        chk("rr2_iresp_valid", iresp_valid, 0);
        step(); step();
        chk("rr3_addr", mem_addr, 64'h8000_1000);
        chk("rr3_we", mem_we, 0);
        chk("rr3_wstrb", mem_wstrb, 0);
        serve(64'h3333_3333_4444_4444);
        chk("rr3_iresp_valid", iresp_valid, 1);
        chk("rr3_iresp_data", iresp_data, 32'h4444_4444);
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        step();

        // Reset while REQ is stalled; the following tie must go to IFU again
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0040;
        step();
        chk("ra_req_valid", mem_req_valid, 1);
        rst = 1'b1;
        step();
        chk("ra_req_valid_after", mem_req_valid, 0);
        chk("ra_busy", busy, 0);
        chk("ra_iresp_valid", iresp_valid, 0);
        chk("ra_dresp_valid", dresp_valid, 0);
        rst = 1'b0;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_0080; dreq_we = 1'b0;
        step();
        chk("ra_tie_addr", mem_addr, 64'h8000_0040);
        chk("ra_tie_req_valid", mem_req_valid, 1);
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        serve(64'h0);
        chk("ra_tie_iresp_valid", iresp_valid, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (IFU) and the data requester (MEMU) of the multi-cycle RV64 core.
- Grants one requester at a time with round-robin tie-break and drives the memory request/response handshake.
- Returns a one-cycle response pulse to the granted requester.
- Enforces a response timeout and rejects misaligned instruction fetches without touching memory.

Parameters:
- ADDR_WIDTH, 64, width of all address buses.
- DATA_WIDTH, 64, memory data width; fixed at 64 (the IFU lane select depends on it).
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ireq_valid  in  1  IFU request; held with stable address until iresp_valid.
- ireq_addr  in  ADDR_WIDTH  fetch address.
- iresp_valid  out  1  one-cycle IFU response pulse.
- iresp_data  out  32  fetched instruction.
- iresp_err  out  1  error qualifier for iresp_valid.
- dreq_valid  in  1  MEMU request; held with stable fields until dresp_valid.
- dreq_addr  in  ADDR_WIDTH  data address.
- dreq_we  in  1  1 = store.
- dreq_wdata  in  64  store data.
- dreq_wstrb  in  8  store byte enables.
- dresp_valid  out  1  one-cycle MEMU response pulse.
- dresp_data  out  64  load data.
- dresp_err  out  1  error qualifier for dresp_valid.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_we  out  1  latched write enable.
- mem_wdata  out  64  latched store data.
- mem_wstrb  out  8  latched byte enables.
- mem_resp_valid  in  1  memory response.
- mem_resp_data  in  64  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset values:
  - state = IDLE.
  - last_grant = DATA, so the first tie goes to IFU.
  - All response outputs 0: iresp/dresp valid, err and data.
  - mem_req_valid = 0; mem_addr, mem_we, mem_wdata, mem_wstrb = 0.
  - Timeout counter = 0; busy = 0.
- Reset mid-operation aborts any transfer, including a pending mem_req_valid/mem_req_ready handshake. No response is issued for the aborted request.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: grant that requester.
  - Both valid: grant the requester opposite last_grant.
  - On grant: latch addr/we/wdata/wstrb (IFU forces we=0, wstrb=0), update last_grant, go to REQ.
  - Exception: an IFU grant with ireq_addr[1:0] != 0 goes directly to RESP with err=1 and data=0, and no memory access is made.
- REQ: mem_req_valid = 1 and latched fields are driven. Stay until mem_req_ready = 1, then go to WAIT with the counter cleared.
- WAIT:
  - mem_resp_valid = 1: capture mem_resp_data and go to RESP with err=0.
  - Otherwise the counter increments.
  - TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 without a response: go to RESP with err=1, data=0.
- RESP:
  - Exactly one of iresp_valid/dresp_valid is high for one cycle (the granted side), with the registered err and data. Then go to IDLE.
  - iresp_data = latched addr[2] ? resp[63:32] : resp[31:0].
  - dresp_data = full 64 bits; for stores, dresp_data = 0.
- Requesters update valid on the same edge that ends RESP, so IDLE samples fresh request state. A requester still holding valid is treated as a new request.
- Ignored inputs:
  - mem_resp_valid outside WAIT, including late responses after a timeout.
  - mem_req_ready outside REQ.
- Request inputs are sampled only in IDLE. Changes during REQ/WAIT/RESP have no effect.
- Minimum latency with zero-wait memory: request seen at cycle 0, mem_req_valid at cycle 1, response accepted at cycle 2, resp_valid at cycle 3.
- Response outputs hold their values outside RESP; only the valid pulses return to 0.

Test Plan:
- Single load: dreq addr=0x80000008, ready in the REQ cycle, mem_resp_data=0x1122334455667788 next cycle -> dresp_valid at cycle 3 with that data, err=0; iresp_valid stays 0.
- IFU lane select: ireq addr=0x80000004 with mem_resp_data=0xAAAAAAAA_BBBBBBBB -> iresp_data=0xAAAAAAAA; addr=0x80000000 -> 0xBBBBBBBB.
- Simultaneous requests, held for three rounds from reset -> grant order IFU, DATA, IFU. The store grant drives mem_we=1 with wstrb and wdata passed through.
- Misaligned fetch addr=0x80000002 -> iresp_valid, err=1, data=0 at cycle 1; mem_req_valid never asserts.
- Timeout with TIMEOUT_CYCLES=4 and no mem_resp_valid -> dresp_err=1 after 4 WAIT cycles. A mem_resp_valid arriving one cycle later is ignored and state is IDLE.
- rst asserted in REQ with mem_req_ready=0 -> next cycle mem_req_valid=0, busy=0, no response pulse. A subsequent tie grants IFU.
